// File: rtl/fifo_uart_tx_drain.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends it LSB first, idle high.
// Optional even parity bit between data and stop bits when PARITY_EN is defined.
module fifo_uart_tx_drain #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Enable_In,
    input  logic       Fifo_Empty_In,
    input  logic [7:0] Fifo_Data_In,
    output logic       Fifo_Read_Enable_Out,
    output logic       Tx_Out,
    output logic       Busy_Out,
    output logic       Byte_Done_Out
);

    localparam int unsigned     BaudW    = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
`ifdef PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              bit_end;
`ifdef PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BaudLast);

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (Enable_In && !Fifo_Empty_In) state_d = StFetch;
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                state_d  = StStart;
                shift_d  = Fifo_Data_In;
                baud_d   = '0;
                bit_d    = '0;
`ifdef PARITY_EN
                parity_d = ^Fifo_Data_In;
`endif
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        state_d = StIdle;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is derived from the next state so Tx_Out aligns with state_q.
        tx_d = 1'b1;
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        Fifo_Read_Enable_Out = (state_q == StFetch);
        Busy_Out             = (state_q != StIdle);
        Byte_Done_Out        = (state_q == StStop) && bit_end && (bit_q == StopLast);
        Tx_Out               = tx_q;
    end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: FIFO model plus a frame-level expected waveform queue,
// directed scenarios followed by a randomized push/enable phase.
module tb_fifo_uart_tx_drain;

    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct packed {
        logic tx;
        logic strobe;
        logic done;
        logic busy;
    } rec_t;

    logic       Clk_In = 1'b0;
    logic       Reset_In = 1'b1;
    logic       Enable_In = 1'b0;
    logic       Fifo_Empty_In = 1'b1;
    logic [7:0] Fifo_Data_In = 8'h00;
    logic       Fifo_Read_Enable_Out;
    logic       Tx_Out;
    logic       Busy_Out;
    logic       Byte_Done_Out;

    fifo_uart_tx_drain #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .Clk_In              (Clk_In),
        .Reset_In            (Reset_In),
        .Enable_In           (Enable_In),
        .Fifo_Empty_In       (Fifo_Empty_In),
        .Fifo_Data_In        (Fifo_Data_In),
        .Fifo_Read_Enable_Out(Fifo_Read_Enable_Out),
        .Tx_Out              (Tx_Out),
        .Busy_Out            (Busy_Out),
        .Byte_Done_Out       (Byte_Done_Out)
    );

    always #5 Clk_In = ~Clk_In;

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         cycle     = 0;
    int         pops, strobes, dones, pushed;
    logic [7:0] fifo_q[$];
    rec_t       exp_seq[$];
    logic       tx_trace[$];
    bit         cur_idle = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h, expected %0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic tx, input logic st, input logic dn, input logic bz);
        rec_t r;
        r.tx = tx; r.strobe = st; r.done = dn; r.busy = bz;
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        Fifo_Empty_In = 1'b0;
        pushed++;
    endtask

    // Expected per-cycle outputs for one frame: FETCH, LOAD, then each bit held CPB cycles.
    task automatic build_frame(input logic [7:0] b);
        int   nbits = 1 + 8 + P + SB;
        logic v;
        exp_seq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
        exp_seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)                 v = 1'b0;
            else if (i <= 8)            v = b[i-1];
            else if (P == 1 && i == 9)  v = ^b;
            else                        v = 1'b1;
            for (int c = 0; c < CPB; c++)
                exp_seq.push_back(mk(v, 1'b0, (i == nbits - 1) && (c == CPB - 1), 1'b1));
        end
    endtask

    task automatic step();
        rec_t e;
        if (!Reset_In && cur_idle && Enable_In && !Fifo_Empty_In) build_frame(fifo_q[0]);
        @(negedge Clk_In);
        cycle++;
        if (Reset_In) exp_seq.delete();
        if (exp_seq.size() > 0) begin
            e = exp_seq.pop_front();
            cur_idle = 1'b0;
        end else begin
            e = mk(1'b1, 1'b0, 1'b0, 1'b0);
            cur_idle = 1'b1;
        end
        check("tx", 32'(Tx_Out), 32'(e.tx));
        check("strobe", 32'(Fifo_Read_Enable_Out), 32'(e.strobe));
        check("byte_done", 32'(Byte_Done_Out), 32'(e.done));
        check("busy", 32'(Busy_Out), 32'(e.busy));
        tx_trace.push_back(Tx_Out);
        if (Byte_Done_Out) dones++;
        if (Fifo_Read_Enable_Out) begin
            strobes++;
            if (fifo_q.size() > 0) begin
                Fifo_Data_In = fifo_q.pop_front();
                pops++;
            end
            Fifo_Empty_In = (fifo_q.size() == 0);
        end
    endtask

    task automatic clear_stats();
        pops = 0; strobes = 0; dones = 0; pushed = 0;
        tx_trace.delete();
    endtask

    function automatic int first_low();
        for (int i = 0; i < tx_trace.size(); i++)
            if (tx_trace[i] == 1'b0) return i;
        return -1;
    endfunction

    // Length of the high run separating the first two low stretches of the trace.
    function automatic int high_gap();
        int i = first_low();
        int n = 0;
        if (i < 0) return -1;
        while (i < tx_trace.size() && tx_trace[i] == 1'b0) i++;
        while (i < tx_trace.size() && tx_trace[i] == 1'b1) begin
            n++;
            i++;
        end
        if (i >= tx_trace.size()) return -1;
        return n;
    endfunction

    initial begin
        int         s;
        logic [9:0] a5_bits;
        a5_bits = 10'b1101001010;

        // Reset held with a byte queued and enable high: nothing may be popped.
        clear_stats();
        Enable_In = 1'b1;
        push(8'hA5);
        repeat (6) step();
        check("reset_pops", 32'(pops), 32'd0);

        // Single byte.
        Reset_In = 1'b0;
        clear_stats();
        repeat (50) step();
        check("single_strobes", 32'(strobes), 32'd1);
        check("single_pops", 32'(pops), 32'd1);
        check("single_dones", 32'(dones), 32'd1);
        check("single_busy_end", 32'(Busy_Out), 32'd0);
`ifndef PARITY_EN
        s = first_low();
        check("a5_start_found", 32'(s >= 0), 32'd1);
        if (s >= 0)
            for (int i = 0; i < 10; i++)
                check("a5_bit", 32'(tx_trace[s + CPB * i + 1]), 32'(a5_bits[i]));
`endif

        // Back-to-back 0x00, 0xFF.
        clear_stats();
        push(8'h00);
        push(8'hFF);
        repeat (100) step();
        check("b2b_strobes", 32'(strobes), 32'd2);
        check("b2b_pops", 32'(pops), 32'd2);
        check("b2b_dones", 32'(dones), 32'd2);
        check("b2b_gap", 32'(high_gap()), 32'(CPB * SB + 3));
        check("b2b_empty", 32'(Fifo_Empty_In), 32'd1);

        // Disable during data bit 3 of 0x3C with 0x55 still queued.
        clear_stats();
        push(8'h3C);
        push(8'h55);
        repeat (20) step();
        Enable_In = 1'b0;
        repeat (80) step();
        check("dis_pops", 32'(pops), 32'd1);
        check("dis_dones", 32'(dones), 32'd1);
        check("dis_left", 32'(fifo_q.size()), 32'd1);
        if (fifo_q.size() > 0) check("dis_left_byte", 32'(fifo_q[0]), 32'h55);

        // Reset during data bit 5 of 0x55; 0x55 is lost, 0x81 follows cleanly.
        clear_stats();
        Enable_In = 1'b1;
        repeat (28) step();
        Reset_In = 1'b1;
        #1;
        check("rst_mid_tx", 32'(Tx_Out), 32'd1);
        check("rst_mid_busy", 32'(Busy_Out), 32'd0);
        check("rst_mid_strobe", 32'(Fifo_Read_Enable_Out), 32'd0);
        repeat (3) step();
        push(8'h81);
        Reset_In = 1'b0;
        repeat (50) step();
        check("rst_pops", 32'(pops), 32'd2);
        check("rst_dones", 32'(dones), 32'd1);
        check("rst_empty", 32'(fifo_q.size()), 32'd0);

`ifdef PARITY_EN
        clear_stats();
        push(8'h07);
        push(8'h03);
        repeat (100) step();
        check("par_dones", 32'(dones), 32'd2);
`endif

        // Randomized pushes and enable toggling, then drain.
        clear_stats();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0 && fifo_q.size() < 4) push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 49) == 0) Enable_In = ~Enable_In;
            step();
        end
        Enable_In = 1'b1;
        repeat (300) step();
        check("rand_pops", 32'(pops), 32'(pushed));
        check("rand_dones", 32'(dones), 32'(pushed));
        check("rand_empty", 32'(fifo_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
